// File: rtl/dp_memory_pkg.sv
// Shared types and default parameter values for the dp_memory RAM and its
// clear sequencer.
package dp_memory_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    localparam int DEF_DATA_W   = 8;
    localparam int DEF_ADDR_W   = 6;
    localparam int DEF_INIT_VAL = 0;

endpackage

// File: rtl/dp_memory_clr_seq.sv
// Clear sequencer for dp_memory: owns the array after reset or a clr request
// and sweeps every address once, lowest first.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   CLEAR | sweep in progress, writes INIT_VAL to clr_addr every cycle
//   IDLE  | array released to the read and write ports
module dp_memory_clr_seq
    import dp_memory_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    output logic              busy,
    output logic              seq_we,
    output logic [ADDR_W-1:0] seq_addr
);

    clr_state_t        state;
    clr_state_t        state_nxt;
    logic [ADDR_W-1:0] clr_addr;
    logic [ADDR_W-1:0] clr_addr_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= CLEAR;
            clr_addr <= '0;
        end else begin
            state    <= state_nxt;
            clr_addr <= clr_addr_nxt;
        end
    end

    // clr during a sweep is deliberately ignored; the sweep never restarts.
    always_comb begin
        state_nxt    = state;
        clr_addr_nxt = clr_addr;
        case (state)
            CLEAR: begin
                clr_addr_nxt = clr_addr + ADDR_W'(1);
                if (&clr_addr) begin
                    state_nxt = IDLE;
                end
            end
            IDLE: begin
                if (clr) begin
                    state_nxt    = CLEAR;
                    clr_addr_nxt = '0;
                end
            end
            default: begin
                state_nxt    = CLEAR;
                clr_addr_nxt = '0;
            end
        endcase
    end

    always_comb begin
        busy     = (state == CLEAR);
        seq_we   = (state == CLEAR);
        seq_addr = clr_addr;
    end

endmodule

// File: rtl/dp_memory.sv
// Simple-dual-port synchronous RAM with registered read and a clear sweep.
// Define DP_MEMORY_BYPASS_EN for write-first same-address reads; default is read-first.
module dp_memory
    import dp_memory_pkg::*;
#(
    parameter int                DATA_W   = DEF_DATA_W,
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter logic [DATA_W-1:0] INIT_VAL = DATA_W'(DEF_INIT_VAL)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    output logic              busy,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              seq_we;
    logic [ADDR_W-1:0] seq_addr;
    logic              wr_fire;
    logic              rd_fire;
    logic [DATA_W-1:0] rd_word;

    dp_memory_clr_seq #(
        .ADDR_W (ADDR_W)
    ) u_clr_seq (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .busy     (busy),
        .seq_we   (seq_we),
        .seq_addr (seq_addr)
    );

    assign wr_fire = wr_en & ~busy;
    assign rd_fire = rd_en & ~busy;

    // The array itself has no reset; the sweep defines its contents.
    always_ff @(posedge clk) begin
        if (seq_we) begin
            mem[seq_addr] <= INIT_VAL;
        end else if (wr_fire) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_word = mem[rd_addr];
`ifdef DP_MEMORY_BYPASS_EN
        if (wr_fire && (wr_addr == rd_addr)) begin
            rd_word = wr_data;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_fire;
            if (rd_fire) begin
                rd_data <= rd_word;
            end
        end
    end

endmodule

// File: tb/tb_dp_memory.sv
// Self-checking bench for dp_memory: a 8x64 instance driven against an
// array-based reference model, plus a 16x8 instance checked directly.
module tb_dp_memory;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // 8x64 instance, INIT_VAL = A5
    logic       rst_n_a = 1'b0, clr_a = 1'b0, busy_a;
    logic       wr_en_a = 1'b0, rd_en_a = 1'b0, rd_valid_a;
    logic [5:0] wr_addr_a = '0, rd_addr_a = '0;
    logic [7:0] wr_data_a = '0, rd_data_a;

    // 16x8 instance, INIT_VAL = 0
    logic        rst_n_b = 1'b0, clr_b = 1'b0, busy_b;
    logic        wr_en_b = 1'b0, rd_en_b = 1'b0, rd_valid_b;
    logic [2:0]  wr_addr_b = '0, rd_addr_b = '0;
    logic [15:0] wr_data_b = '0, rd_data_b;

    dp_memory #(.DATA_W(8), .ADDR_W(6), .INIT_VAL(8'hA5)) u_dut_a (
        .clk(clk), .rst_n(rst_n_a), .clr(clr_a), .busy(busy_a),
        .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
        .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
        .rd_valid(rd_valid_a)
    );

    dp_memory #(.DATA_W(16), .ADDR_W(3)) u_dut_b (
        .clk(clk), .rst_n(rst_n_b), .clr(clr_b), .busy(busy_b),
        .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
        .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
        .rd_valid(rd_valid_b)
    );

    // Reference model: contents, cycles of clear still to run, read outputs.
    logic [7:0] m_mem [64];
    int         m_left  = 0;
    logic       m_valid = 1'b0;
    logic [7:0] m_data  = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic fill_model();
        for (int i = 0; i < 64; i++) m_mem[i] = 8'hA5;
    endtask

    // One clock of DUT A: advance the model on the edge, compare just after.
    task automatic tick_a();
        @(posedge clk);
        if (!rst_n_a) begin
            m_left  = 64;
            m_valid = 1'b0;
            m_data  = 8'h00;
            fill_model();
        end else if (m_left > 0) begin
            m_left--;
            m_valid = 1'b0;
        end else begin
            m_valid = rd_en_a;
            if (rd_en_a) begin
                m_data = m_mem[rd_addr_a];
`ifdef DP_MEMORY_BYPASS_EN
                if (wr_en_a && wr_addr_a == rd_addr_a) m_data = wr_data_a;
`endif
            end
            if (wr_en_a) m_mem[wr_addr_a] = wr_data_a;
            if (clr_a) begin
                m_left = 64;
                fill_model();
            end
        end
        #1;
        chk("a_busy", 32'(busy_a), 32'(m_left > 0));
        chk("a_rd_valid", 32'(rd_valid_a), 32'(m_valid));
        chk("a_rd_data", 32'(rd_data_a), 32'(m_data));
    endtask

    task automatic idle_a();
        clr_a = 1'b0; wr_en_a = 1'b0; rd_en_a = 1'b0;
    endtask

    task automatic read_a(input logic [5:0] addr);
        rd_en_a = 1'b1; rd_addr_a = addr;
        tick_a();
        rd_en_a = 1'b0;
    endtask

    task automatic tick_b();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cnt;
        logic [7:0] exp_rdw;

        // ---- 16x8 instance ----
        tick_b(); tick_b();
        chk("b_reset_busy", 32'(busy_b), 32'd1);
        chk("b_reset_valid", 32'(rd_valid_b), 32'd0);
        chk("b_reset_data", 32'(rd_data_b), 32'd0);
        rst_n_b = 1'b1;
        cnt = 0;
        while (busy_b && cnt < 20) begin
            tick_b();
            cnt++;
        end
        chk("b_clear_len", 32'(cnt), 32'd8);
        wr_en_b = 1'b1; wr_addr_b = 3'd7; wr_data_b = 16'hBEEF;
        tick_b();
        wr_en_b = 1'b0; rd_en_b = 1'b1; rd_addr_b = 3'd7;
        tick_b();
        chk("b_rd_valid", 32'(rd_valid_b), 32'd1);
        chk("b_rd_data", 32'(rd_data_b), 32'hBEEF);
        rd_addr_b = 3'd0;
        tick_b();
        chk("b_rd_init", 32'(rd_data_b), 32'h0000);
        rd_en_b = 1'b0;
        tick_b();
        chk("b_valid_drop", 32'(rd_valid_b), 32'd0);
        chk("b_data_hold", 32'(rd_data_b), 32'h0000);

        // ---- 8x64 instance: reset and initial sweep ----
        rst_n_a = 1'b0;
        repeat (3) tick_a();
        rst_n_a = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (i == 10) begin
                wr_en_a = 1'b1; wr_addr_a = 6'd3; wr_data_a = 8'h11;
                rd_en_a = 1'b1; rd_addr_a = 6'd3;
            end
            tick_a();
            idle_a();
        end
        chk("a_idle_after_64", 32'(busy_a), 32'd0);
        read_a(6'd0); tick_a();
        read_a(6'd31); tick_a();
        read_a(6'd63); tick_a();

        // ---- write addr pattern, read back back-to-back ----
        for (int i = 0; i < 64; i++) begin
            wr_en_a = 1'b1; wr_addr_a = 6'(i); wr_data_a = 8'(i);
            tick_a();
        end
        wr_en_a = 1'b0;
        for (int i = 0; i < 64; i++) begin
            rd_en_a = 1'b1; rd_addr_a = 6'(i);
            tick_a();
            chk("a_readback", 32'(rd_data_a), 32'(i));
        end
        rd_en_a = 1'b0;
        tick_a();

        // ---- same-cycle read/write of address 5 ----
`ifdef DP_MEMORY_BYPASS_EN
        exp_rdw = 8'hFF;
`else
        exp_rdw = 8'h05;
`endif
        wr_en_a = 1'b1; wr_addr_a = 6'd5; wr_data_a = 8'hFF;
        rd_en_a = 1'b1; rd_addr_a = 6'd5;
        tick_a();
        chk("a_rdw_same", 32'(rd_data_a), 32'(exp_rdw));
        wr_en_a = 1'b0;
        tick_a();
        chk("a_rdw_after", 32'(rd_data_a), 32'hFF);
        rd_en_a = 1'b0;

        // ---- clr pulse, port accesses during the sweep are dropped ----
        clr_a = 1'b1;
        tick_a();
        clr_a = 1'b0;
        chk("a_clr_busy", 32'(busy_a), 32'd1);
        for (int i = 0; i < 64; i++) begin
            if (i == 5) begin
                wr_en_a = 1'b1; wr_addr_a = 6'd3; wr_data_a = 8'h3C;
                rd_en_a = 1'b1; rd_addr_a = 6'd3;
            end
            if (i == 20) clr_a = 1'b1;
            tick_a();
            idle_a();
        end
        for (int i = 0; i < 64; i++) begin
            rd_en_a = 1'b1; rd_addr_a = 6'(i);
            tick_a();
            chk("a_after_clr", 32'(rd_data_a), 32'hA5);
        end
        rd_en_a = 1'b0;

        // ---- reset in the middle of a read burst ----
        for (int i = 0; i < 6; i++) begin
            wr_en_a = 1'b1; wr_addr_a = 6'(i); wr_data_a = 8'(8'h40 + i);
            tick_a();
        end
        wr_en_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rd_en_a = 1'b1; rd_addr_a = 6'(i);
            tick_a();
        end
        rst_n_a = 1'b0;
        tick_a();
        chk("a_rst_valid", 32'(rd_valid_a), 32'd0);
        chk("a_rst_busy", 32'(busy_a), 32'd1);
        rst_n_a = 1'b1;
        cnt = 0;
        while (busy_a && cnt < 100) begin
            tick_a();
            cnt++;
        end
        chk("a_reclear_len", 32'(cnt), 32'd64);
        rd_addr_a = 6'd2;
        tick_a();
        chk("a_overwritten", 32'(rd_data_a), 32'hA5);
        rd_en_a = 1'b0;

        // ---- randomized traffic against the model ----
        for (int i = 0; i < 600; i++) begin
            wr_en_a   = 1'($urandom_range(0, 1));
            wr_addr_a = 6'($urandom_range(0, 63));
            wr_data_a = 8'($urandom);
            rd_en_a   = 1'($urandom_range(0, 1));
            rd_addr_a = ($urandom_range(0, 3) == 0) ? wr_addr_a : 6'($urandom_range(0, 63));
            clr_a     = ($urandom_range(0, 149) == 0);
            rst_n_a   = ($urandom_range(0, 299) != 0);
            tick_a();
        end
        idle_a();
        rst_n_a = 1'b1;
        tick_a();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
